// File: rtl/g_lut_pkg.sv
// Shared constants and FSM state type for the blue-channel inverse camera-response block.
package g_lut_pkg;

  localparam int PIX_W = 5;
  localparam int LOG_W = 8;
  localparam int BIT_W = $clog2(PIX_W);

  localparam logic [LOG_W-1:0] CURVE_MAX = 8'h49;
  localparam logic [PIX_W-1:0] PIX_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    ROUND,
    DONE
  } state_t;

endpackage

// File: rtl/g_blue_curve_rom.sv
// Combinational 32x8 read of the blue-channel camera response g(); the curve is non-decreasing.
module g_blue_curve_rom
  import g_lut_pkg::*;
(
  input  logic [PIX_W-1:0] addr,
  output logic [LOG_W-1:0] data
);

  always_comb begin
    data = CURVE_MAX;
    case (addr)
      5'd0:  data = 8'h00;
      5'd1:  data = 8'h0B;
      5'd2:  data = 8'h11;
      5'd3:  data = 8'h16;
      5'd4:  data = 8'h19;
      5'd5:  data = 8'h1D;
      5'd6:  data = 8'h1F;
      5'd7:  data = 8'h21;
      5'd8:  data = 8'h23;
      5'd9:  data = 8'h25;
      5'd10: data = 8'h26;
      5'd11: data = 8'h28;
      5'd12: data = 8'h2A;
      5'd13: data = 8'h2C;
      5'd14: data = 8'h2E;
      5'd15: data = 8'h30;
      5'd16: data = 8'h32;
      5'd17: data = 8'h34;
      5'd18: data = 8'h36;
      5'd19: data = 8'h37;
      5'd20: data = 8'h39;
      5'd21: data = 8'h3A;
      5'd22: data = 8'h3C;
      5'd23: data = 8'h3D;
      5'd24: data = 8'h3F;
      5'd25: data = 8'h40;
      5'd26: data = 8'h40;
      5'd27: data = 8'h41;
      5'd28: data = 8'h42;
      5'd29: data = 8'h43;
      5'd30: data = 8'h44;
      default: data = CURVE_MAX;
    endcase
  end

endmodule

// File: rtl/g_blue_inv_lut.sv
// Inverse of g(): bit-serial search for the largest pixel code p with g(p) <= in_log.
// Define G_INV_ROUND_EN to add a ROUND state that picks the nearer of g(p) and g(p+1).
module g_blue_inv_lut
  import g_lut_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LOG_W-1:0] in_log,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_pixel
);

  state_t           state;
  state_t           next_state;
  logic [LOG_W-1:0] x;
  logic [PIX_W-1:0] p;
  logic [BIT_W-1:0] bit_idx;
  logic [PIX_W-1:0] t;
  logic [PIX_W-1:0] rom_addr;
  logic [LOG_W-1:0] g_probe;
  logic             take;
  logic             last_bit;

  // Candidate code: current prefix with the bit under test forced high.
  assign t        = p | (PIX_W'(1) << bit_idx);
  assign take     = (g_probe <= x);
  assign last_bit = (bit_idx == '0);

`ifdef G_INV_ROUND_EN
  logic [LOG_W-1:0] g_low;
  logic [LOG_W-1:0] diff_hi;
  logic [LOG_W-1:0] diff_lo;
  logic             round_up;

  // In ROUND the shared port reads g(p+1); a second read gives g(p).
  assign rom_addr = (state == ROUND) ? (p + PIX_W'(1)) : t;

  g_blue_curve_rom u_rom_low (
    .addr (p),
    .data (g_low)
  );

  assign diff_hi  = g_probe - x;
  assign diff_lo  = x - g_low;
  assign round_up = (p != PIX_MAX) && (diff_hi < diff_lo);
`else
  assign rom_addr = t;
`endif

  g_blue_curve_rom u_rom (
    .addr (rom_addr),
    .data (g_probe)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (clk_en) begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (in_valid) next_state = SEARCH;
      end
      SEARCH: begin
`ifdef G_INV_ROUND_EN
        if (last_bit) next_state = ROUND;
`else
        if (last_bit) next_state = DONE;
`endif
      end
      ROUND: begin
        next_state = DONE;
      end
      DONE: begin
        if (out_ready) next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE);
  end

  // Datapath follows the same state decode; everything freezes while clk_en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x         <= '0;
      p         <= '0;
      bit_idx   <= '0;
      out_valid <= 1'b0;
      out_pixel <= '0;
    end else if (clk_en) begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x       <= in_log;
            p       <= '0;
            bit_idx <= BIT_W'(PIX_W - 1);
          end
        end
        SEARCH: begin
          if (take) p <= t;
          bit_idx <= bit_idx - BIT_W'(1);
`ifndef G_INV_ROUND_EN
          if (last_bit) begin
            out_valid <= 1'b1;
            out_pixel <= take ? t : p;
          end
`endif
        end
`ifdef G_INV_ROUND_EN
        ROUND: begin
          out_valid <= 1'b1;
          out_pixel <= round_up ? (p + PIX_W'(1)) : p;
        end
`endif
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_g_blue_inv_lut.sv
// Self-checking bench for g_blue_inv_lut: directed corner cases plus random values against a linear-scan model.
module tb_g_blue_inv_lut;

  logic       clk;
  logic       rst_n;
  logic       clk_en;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_log;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_pixel;

  int checks;
  int errors;

`ifdef G_INV_ROUND_EN
  localparam int         EXP_LAT = 6;
  localparam logic [4:0] EXP_10  = 5'h02;
`else
  localparam int         EXP_LAT = 5;
  localparam logic [4:0] EXP_10  = 5'h01;
`endif

  logic [7:0] curve [0:31] = '{
    8'h00, 8'h0B, 8'h11, 8'h16, 8'h19, 8'h1D, 8'h1F, 8'h21,
    8'h23, 8'h25, 8'h26, 8'h28, 8'h2A, 8'h2C, 8'h2E, 8'h30,
    8'h32, 8'h34, 8'h36, 8'h37, 8'h39, 8'h3A, 8'h3C, 8'h3D,
    8'h3F, 8'h40, 8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h49
  };

  g_blue_inv_lut dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_en    (clk_en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_log    (in_log),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pixel (out_pixel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Linear scan for the largest code whose curve value does not exceed x, then optional nearest rounding.
  function automatic logic [4:0] ref_pixel(input logic [7:0] x);
    int best;
    best = 0;
    for (int i = 0; i < 32; i++) begin
      if (curve[i] <= x) best = i;
    end
`ifdef G_INV_ROUND_EN
    if (best < 31) begin
      if ((int'(curve[best + 1]) - int'(x)) < (int'(x) - int'(curve[best]))) best = best + 1;
    end
`endif
    return 5'(best);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Offers one value, waits for acceptance, optionally drops clk_en for 3 cycles, and waits for out_valid.
  task automatic applyStimulus(input logic [7:0] val, input int stall_after,
                               output logic [4:0] pix, output int lat);
    int waited;
    waited = 0;
    in_log   = val;
    in_valid = 1'b1;
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    tick();
    in_valid = 1'b0;
    in_log   = 8'($urandom);
    lat = 0;
    while (!out_valid && lat < 60) begin
      if (lat == stall_after) clk_en = 1'b0;
      if (lat == stall_after + 3) clk_en = 1'b1;
      tick();
      lat++;
    end
    clk_en = 1'b1;
    pix    = out_pixel;
  endtask

  task automatic releaseOutput();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic runTxn(input string tag, input logic [7:0] val, input logic [4:0] exp_pix);
    logic [4:0] pix;
    int         lat;
    applyStimulus(val, -1, pix, lat);
    checkOutput({tag, " latency"}, lat, EXP_LAT);
    checkOutput({tag, " pixel"}, pix, exp_pix);
    releaseOutput();
    checkOutput({tag, " valid_after_hs"}, out_valid, 1'b0);
  endtask

  initial begin
    logic [4:0] pix;
    logic [4:0] exp_pix;
    int         lat;
    logic [7:0] v;

    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    clk_en    = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_log    = 8'h00;

    #12;
    checkOutput("reset in_ready", in_ready, 1'b1);
    checkOutput("reset out_valid", out_valid, 1'b0);
    checkOutput("reset out_pixel", out_pixel, 5'h00);
    rst_n = 1'b1;
    tick();

    $display("[TB] directed corner values");
    runTxn("zero", 8'h00, 5'h00);
    runTxn("g1", 8'h0B, 5'h01);
    runTxn("curve_max", 8'h49, 5'h1F);
    runTxn("duplicate", 8'h40, 5'h1A);
    runTxn("saturate", 8'hFF, 5'h1F);
    runTxn("between_1_2", 8'h10, EXP_10);
    runTxn("exact_tie", 8'h26, 5'h0A);

    $display("[TB] backpressure in DONE");
    exp_pix = ref_pixel(8'h2C);
    applyStimulus(8'h2C, -1, pix, lat);
    checkOutput("bp pixel", pix, exp_pix);
    in_valid = 1'b1;
    in_log   = 8'h00;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("bp out_valid", out_valid, 1'b1);
      checkOutput("bp out_pixel", out_pixel, exp_pix);
      checkOutput("bp in_ready", in_ready, 1'b0);
    end
    in_valid  = 1'b0;
    clk_en    = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    checkOutput("gated hs out_valid", out_valid, 1'b1);
    checkOutput("gated hs in_ready", in_ready, 1'b0);
    clk_en = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("hs out_valid", out_valid, 1'b0);
    checkOutput("hs in_ready", in_ready, 1'b1);

    $display("[TB] clk_en gating");
    clk_en   = 1'b0;
    in_valid = 1'b1;
    in_log   = 8'h30;
    tick();
    tick();
    checkOutput("gated accept in_ready", in_ready, 1'b1);
    in_valid = 1'b0;
    clk_en   = 1'b1;
    tick();
    exp_pix = ref_pixel(8'h3A);
    applyStimulus(8'h3A, 2, pix, lat);
    checkOutput("stall latency", lat, EXP_LAT + 3);
    checkOutput("stall pixel", pix, exp_pix);
    releaseOutput();

    $display("[TB] reset mid-search");
    in_log   = 8'h37;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checkOutput("midrst in_ready", in_ready, 1'b1);
    checkOutput("midrst out_valid", out_valid, 1'b0);
    checkOutput("midrst out_pixel", out_pixel, 5'h00);
    #2;
    rst_n = 1'b1;
    tick();
    runTxn("post_reset", 8'h37, ref_pixel(8'h37));

    $display("[TB] random values");
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) v = 8'($urandom_range(0, 255));
      else            v = 8'($urandom_range(0, 8'h4F));
      runTxn("random", v, ref_pixel(v));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
